// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file: data width, register
// count, read-port count and the derived address width.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

  localparam int AW_DEF = addr_width(NREGS_DEF);

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set by an accepted
// reservation and cleared by writeback, with a running count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] readreg,
  output logic [NRD-1:0]    readbusy,
  input  logic              RegWrite,
  input  logic [AW-1:0]     writereg,
  input  logic              reserve,
  input  logic [AW-1:0]     reservereg,
  output logic              reserve_ok,
  output logic [AW:0]       npending
);

  logic [NREGS-1:0] busy;
  logic             wr_hit;
  logic             set_en;
  logic             set_new;
  logic             clr_en;

  assign wr_hit = RegWrite && (writereg != '0);

  // A writeback to the register being reserved frees it on the same edge.
  assign reserve_ok = (reservereg == '0) || !busy[reservereg] ||
                      (RegWrite && (writereg == reservereg));

  assign set_en  = reserve && reserve_ok && (reservereg != '0);
  assign set_new = set_en && !busy[reservereg];
  // A same-edge reservation of the written register wins over the clear.
  assign clr_en  = wr_hit && busy[writereg] &&
                   !(set_en && (reservereg == writereg));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    readbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      readbusy[i] = busy[readreg[i*AW +: AW]] &&
                    !(RegWrite && (writereg == readreg[i*AW +: AW]));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      npending <= '0;
    end else begin
      if (clr_en) busy[writereg]   <= 1'b0;
      if (set_en) busy[reservereg] <= 1'b1;
      npending <= npending + (AW+1)'(set_new) - (AW+1)'(clr_en);
    end
  end

endmodule

// File: rtl/regfile_scb.sv
// Multi-port register file with write bypass, hardwired x0 and a busy-bit
// scoreboard tracking registers that await writeback.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   readreg,
  output logic [NRD*XLEN-1:0] readdata,
  output logic [NRD-1:0]      readbusy,
  input  logic                RegWrite,
  input  logic [AW-1:0]       writereg,
  input  logic [XLEN-1:0]     writedata,
  input  logic                reserve,
  input  logic [AW-1:0]       reservereg,
  output logic                reserve_ok,
  output logic [AW:0]         npending
);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the register array is flop-based and must clear on reset, so every entry is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (RegWrite && (writereg != '0)) begin
      regs[writereg] <= writedata;
    end
  end

  // Bypass is suppressed during reset so outputs show cleared state at once.
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NRD; i++) begin
      if (readreg[i*AW +: AW] == '0)
        readdata[i*XLEN +: XLEN] = '0;
      else if (!reset && RegWrite && (writereg == readreg[i*AW +: AW]))
        readdata[i*XLEN +: XLEN] = writedata;
      else
        readdata[i*XLEN +: XLEN] = regs[readreg[i*AW +: AW]];
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .readreg    (readreg),
    .readbusy   (readbusy),
    .RegWrite   (RegWrite),
    .writereg   (writereg),
    .reserve    (reserve),
    .reservereg (reservereg),
    .reserve_ok (reserve_ok),
    .npending   (npending)
  );

endmodule

// File: tb/tb_regfile_scb.sv
// Scoreboard-driven bench for regfile_scb: a default 64x32x2 instance and a
// 32-bit, 16-register, 4-port instance.
module tb_regfile_scb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [9:0]   readreg_a;
  logic [127:0] readdata_a;
  logic [1:0]   readbusy_a;
  logic         regwrite_a;
  logic [4:0]   writereg_a;
  logic [63:0]  writedata_a;
  logic         reserve_a;
  logic [4:0]   reservereg_a;
  logic         reserve_ok_a;
  logic [5:0]   npending_a;

  logic [15:0]  readreg_b;
  logic [127:0] readdata_b;
  logic [3:0]   readbusy_b;
  logic         regwrite_b;
  logic [3:0]   writereg_b;
  logic [31:0]  writedata_b;
  logic         reserve_b;
  logic [3:0]   reservereg_b;
  logic         reserve_ok_b;
  logic [4:0]   npending_b;

  regfile_scb dut_a (
    .clk(clk), .reset(reset), .readreg(readreg_a), .readdata(readdata_a),
    .readbusy(readbusy_a), .RegWrite(regwrite_a), .writereg(writereg_a),
    .writedata(writedata_a), .reserve(reserve_a), .reservereg(reservereg_a),
    .reserve_ok(reserve_ok_a), .npending(npending_a)
  );

  regfile_scb #(.XLEN(32), .NREGS(16), .NRD(4)) dut_b (
    .clk(clk), .reset(reset), .readreg(readreg_b), .readdata(readdata_b),
    .readbusy(readbusy_b), .RegWrite(regwrite_b), .writereg(writereg_b),
    .writedata(writedata_b), .reserve(reserve_b), .reservereg(reservereg_b),
    .reserve_ok(reserve_ok_b), .npending(npending_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] model_b [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [63:0] act);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, act, e.val);
    end
  endtask

  function automatic logic [63:0] rd_a(input int p);
    return readdata_a[p*64 +: 64];
  endfunction

  function automatic logic [63:0] rd_b(input int p);
    return {32'd0, readdata_b[p*32 +: 32]};
  endfunction

  task automatic idle_a();
    regwrite_a = 0; writereg_a = 0; writedata_a = 0;
    reserve_a = 0; reservereg_a = 0; readreg_a = 0;
  endtask

  task automatic idle_b();
    regwrite_b = 0; writereg_b = 0; writedata_b = 0;
    reserve_b = 0; reservereg_b = 0; readreg_b = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pats [3][4];
    pats = '{'{1, 5, 5, 15}, '{0, 7, 7, 7}, '{3, 9, 12, 3}};

    reset = 1'b1;
    idle_a();
    idle_b();

    // Reset values with live write/reserve traffic present
    #2;
    regwrite_a = 1; writereg_a = 2; writedata_a = 64'h55;
    readreg_a = {5'd2, 5'd2}; reserve_a = 1; reservereg_a = 4;
    push_exp("rst_rd0", 0); push_exp("rst_rd1", 0);
    push_exp("rst_busy", 0); push_exp("rst_ok", 1); push_exp("rst_np", 0);
    #1;
    pop_cmp(rd_a(0)); pop_cmp(rd_a(1));
    pop_cmp(readbusy_a); pop_cmp(reserve_ok_a); pop_cmp(npending_a);
    tick();
    @(negedge clk);
    reset = 1'b0;
    idle_a();
    readreg_a = {5'd2, 5'd0};
    push_exp("rst_write_ignored", 0);
    #1 pop_cmp(rd_a(1));

    // Write x2=32 with bypass, then stored read, then bypass of 45
    @(negedge clk);
    regwrite_a = 1; writereg_a = 2; writedata_a = 64'd32; readreg_a = {5'd2, 5'd0};
    push_exp("byp32", 32);
    #1 pop_cmp(rd_a(1));
    tick();
    @(negedge clk);
    idle_a(); readreg_a = {5'd2, 5'd0};
    push_exp("rd_x0", 0); push_exp("rd_x2", 32);
    #1 pop_cmp(rd_a(0)); pop_cmp(rd_a(1));
    @(negedge clk);
    regwrite_a = 1; writereg_a = 2; writedata_a = 64'd45; readreg_a = {5'd2, 5'd0};
    push_exp("byp45", 45);
    #1 pop_cmp(rd_a(1));
    tick();

    // x0 hardwired: write ignored, reserve always accepted, no count change
    @(negedge clk);
    idle_a();
    regwrite_a = 1; writereg_a = 0; writedata_a = 64'hFFFF;
    reserve_a = 1; reservereg_a = 0; readreg_a = {5'd0, 5'd0};
    push_exp("x0_rd0", 0); push_exp("x0_rd1", 0); push_exp("x0_ok", 1);
    #1 pop_cmp(rd_a(0)); pop_cmp(rd_a(1)); pop_cmp(reserve_ok_a);
    tick();
    push_exp("x0_np", 0); push_exp("x0_busy", 0); push_exp("x0_rd_after", 0);
    pop_cmp(npending_a); pop_cmp(readbusy_a); pop_cmp(rd_a(0));

    // Reserve x5, reject second reserve, writeback clears it
    @(negedge clk);
    idle_a(); reserve_a = 1; reservereg_a = 5;
    push_exp("r5_ok", 1);
    #1 pop_cmp(reserve_ok_a);
    tick();
    @(negedge clk);
    idle_a(); readreg_a = {5'd0, 5'd5};
    push_exp("r5_busy", 2'b01); push_exp("r5_np", 1);
    #1 pop_cmp(readbusy_a); pop_cmp(npending_a);
    @(negedge clk);
    reserve_a = 1; reservereg_a = 5;
    push_exp("r5_rej", 0);
    #1 pop_cmp(reserve_ok_a);
    tick();
    push_exp("r5_rej_np", 1);
    pop_cmp(npending_a);
    @(negedge clk);
    idle_a(); regwrite_a = 1; writereg_a = 5; writedata_a = 64'd7; readreg_a = {5'd0, 5'd5};
    push_exp("w5_busy", 0); push_exp("w5_byp", 7);
    #1 pop_cmp(readbusy_a); pop_cmp(rd_a(0));
    tick();
    push_exp("w5_np", 0);
    pop_cmp(npending_a);

    // Same-edge reserve and write of busy x3
    @(negedge clk);
    idle_a(); reserve_a = 1; reservereg_a = 3;
    tick();
    @(negedge clk);
    idle_a(); reserve_a = 1; reservereg_a = 3;
    regwrite_a = 1; writereg_a = 3; writedata_a = 64'd9; readreg_a = {5'd0, 5'd3};
    push_exp("r3_ok", 1); push_exp("r3_byp", 9); push_exp("r3_np_pre", 1);
    #1 pop_cmp(reserve_ok_a); pop_cmp(rd_a(0)); pop_cmp(npending_a);
    tick();
    @(negedge clk);
    idle_a(); readreg_a = {5'd0, 5'd3};
    push_exp("r3_rd", 9); push_exp("r3_busy", 2'b01); push_exp("r3_np", 1);
    #1 pop_cmp(rd_a(0)); pop_cmp(readbusy_a); pop_cmp(npending_a);
    @(negedge clk);
    regwrite_a = 1; writereg_a = 3; writedata_a = 64'd9;
    tick();
    push_exp("r3_clear_np", 0);
    pop_cmp(npending_a);

    // Write to a non-busy register leaves it non-busy
    @(negedge clk);
    idle_a(); regwrite_a = 1; writereg_a = 6; writedata_a = 64'h66;
    tick();
    @(negedge clk);
    idle_a(); readreg_a = {5'd6, 5'd0};
    push_exp("w6_rd", 64'h66); push_exp("w6_busy", 0); push_exp("w6_np", 0);
    #1 pop_cmp(rd_a(1)); pop_cmp(readbusy_a); pop_cmp(npending_a);

    // Reserve x1..x31 in turn
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      idle_a(); reserve_a = 1; reservereg_a = 5'(r);
      push_exp($sformatf("fill_ok_%0d", r), 1);
      #1 pop_cmp(reserve_ok_a);
      tick();
      push_exp($sformatf("fill_np_%0d", r), 64'(r));
      pop_cmp(npending_a);
    end
    @(negedge clk);
    idle_a(); reserve_a = 1; reservereg_a = 7;
    push_exp("full_rej", 0);
    #1 pop_cmp(reserve_ok_a);
    tick();
    push_exp("full_np", 31);
    pop_cmp(npending_a);

    // Asynchronous reset with all registers busy and traffic present
    @(negedge clk);
    idle_a(); regwrite_a = 1; writereg_a = 2; writedata_a = 64'hABCD;
    readreg_a = {5'd2, 5'd2}; reserve_a = 1; reservereg_a = 9;
    #2 reset = 1'b1;
    push_exp("arst_rd0", 0); push_exp("arst_rd1", 0); push_exp("arst_busy", 0);
    push_exp("arst_ok", 1); push_exp("arst_np", 0);
    #1 pop_cmp(rd_a(0)); pop_cmp(rd_a(1)); pop_cmp(readbusy_a);
    pop_cmp(reserve_ok_a); pop_cmp(npending_a);
    tick();
    push_exp("arst_hold_np", 0); push_exp("arst_hold_rd", 0);
    pop_cmp(npending_a); pop_cmp(rd_a(0));
    @(negedge clk);
    reset = 1'b0;
    idle_a(); readreg_a = {5'd5, 5'd2};
    push_exp("arst_x2_cleared", 0); push_exp("arst_x5_cleared", 0); push_exp("arst_busy_cleared", 0);
    #1 pop_cmp(rd_a(0)); pop_cmp(rd_a(1)); pop_cmp(readbusy_a);

    // Second pass, reset mid-sequence
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      idle_a(); reserve_a = 1; reservereg_a = 5'(r);
      tick();
    end
    push_exp("mid_np", 10);
    pop_cmp(npending_a);
    @(negedge clk);
    reserve_a = 1; reservereg_a = 11; readreg_a = {5'd4, 5'd3};
    #2 reset = 1'b1;
    push_exp("mid_rst_np", 0); push_exp("mid_rst_busy", 0);
    #1 pop_cmp(npending_a); pop_cmp(readbusy_a);
    tick();
    @(negedge clk);
    reset = 1'b0;
    idle_a();

    // Four-port instance: distinct and duplicate addresses
    model_b[0] = '0;
    for (int k = 1; k < 16; k++) begin
      model_b[k] = 32'hA500_0000 ^ (32'(k) * 32'h0101_0101);
      @(negedge clk);
      regwrite_b = 1; writereg_b = 4'(k); writedata_b = model_b[k];
      tick();
    end
    @(negedge clk);
    idle_b();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        readreg_b[i*4 +: 4] = 4'(pats[p][i]);
        push_exp($sformatf("b_pat%0d_port%0d", p, i), {32'd0, model_b[pats[p][i]]});
      end
      #1;
      for (int i = 0; i < 4; i++) pop_cmp(rd_b(i));
    end
    @(negedge clk);
    regwrite_b = 1; writereg_b = 9; writedata_b = 32'hDEAD_BEEF;
    readreg_b = {4'd0, 4'd4, 4'd9, 4'd9};
    push_exp("b_byp_p0", 32'hDEAD_BEEF); push_exp("b_byp_p1", 32'hDEAD_BEEF);
    push_exp("b_byp_p2", {32'd0, model_b[4]}); push_exp("b_byp_p3", 0);
    #1 for (int i = 0; i < 4; i++) pop_cmp(rd_b(i));
    tick();
    @(negedge clk);
    idle_b();

    if (exp_q.size() != 0) check("scoreboard_leftover", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scb.md
REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, 2..64.
REQ-003 SHALL have parameter NRD, default 2, number of read ports; 1..4.
REQ-004 SHALL derive AW = clog2(NREGS), default 5; not user-overridable.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port readreg, input, NRD*AW, packed read addresses; port i at bits [i*AW +: AW].
REQ-008 SHALL have port readdata, output, NRD*XLEN, packed read data; port i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have port readbusy, output, NRD, per-port flag: addressed register awaits writeback.
REQ-010 SHALL have port RegWrite, input, 1, write enable.
REQ-011 SHALL have port writereg, input, AW, write address.
REQ-012 SHALL have port writedata, input, XLEN, write data.
REQ-013 SHALL have port reserve, input, 1, request to mark reservereg pending.
REQ-014 SHALL have port reservereg, input, AW, register to reserve.
REQ-015 SHALL have port reserve_ok, output, 1, combinational: reservation accepted this cycle.
REQ-016 SHALL have port npending, output, AW+1, registered count of busy registers.

Function
REQ-017 SHALL write writedata into register writereg on rising clk when RegWrite=1 and writereg!=0.
REQ-018 SHALL hardwire register 0: reads return 0, writes ignored, never busy, reserve of 0 always accepted with no state change.
REQ-019 SHALL drive readdata combinationally: write bypass returns writedata when RegWrite=1, writereg==readreg[i], and readreg[i]!=0; otherwise stored value.
REQ-020 SHALL serve all NRD ports independently; identical addresses on several ports return identical data.
REQ-021 SHALL keep one busy bit per register, set on rising clk when reserve=1, reserve_ok=1, and reservereg!=0.
REQ-022 SHALL clear busy[writereg] on rising clk when RegWrite=1, unless the same edge sets it per REQ-021.
REQ-023 SHALL compute reserve_ok = !busy[reservereg] or (RegWrite and writereg==reservereg); force 1 for reservereg=0.
REQ-024 SHALL make no state change for a rejected reservation (reserve=1, reserve_ok=0).
REQ-025 SHALL end with the register written and busy=1 when RegWrite and accepted reserve target the same nonzero register on the same edge.
REQ-026 SHALL accept writes to non-busy registers; busy stays 0.
REQ-027 SHALL drive readbusy[i] = busy[readreg[i]] and not (RegWrite and writereg==readreg[i]); readbusy is 0 for address 0.
REQ-028 SHALL update npending each edge: +1 per busy set, -1 per busy clear of a set bit; a same-edge set and clear leaves it unchanged; never wraps (max NREGS-1).
REQ-029 SHALL give zero-cycle read latency and one-cycle write latency (value visible through storage on the cycle after the edge).

Reset
REQ-030 SHALL on reset=1 asynchronously clear all registers to 0, all busy bits to 0, and npending to 0.
REQ-031 SHALL let reset override any same-cycle write or reservation; no update occurs while reset=1.
REQ-032 SHALL show reset values on outputs during reset: readdata all 0 (bypass suppressed), readbusy 0, reserve_ok 1, npending 0.

Structure
REQ-033 SHALL take the default XLEN/NREGS/NRD values and AW derivation from a shared package regfile_pkg.
REQ-034 SHALL place the busy vector, reserve_ok logic, and npending counter in sub-module regfile_scoreboard; storage and bypass stay in regfile_scb.

Verification
REQ-035 SHALL test write x2=32, then read ports (0,2): readdata (0,32); same-cycle read of x2 during write of 45 returns 45.
REQ-036 SHALL test write x0=0xFFFF: reads of x0 return 0; reserve x0 gives reserve_ok=1 and npending unchanged.
REQ-037 SHALL test reserve x5: next cycle readbusy=1 and npending=1; second reserve x5 gives reserve_ok=0; write x5=7 gives readbusy=0 in the same cycle, npending=0 after the edge.
REQ-038 SHALL test reserve x3 with same-edge write x3=9 while x3 is busy: reserve_ok=1, x3 reads 9, busy stays 1, npending unchanged.
REQ-039 SHALL test reserving x1..x31 in turn: npending reaches 31; assert reset mid-sequence: all outputs at reset values immediately, state cleared.
REQ-040 SHALL test NRD=4, NREGS=16, XLEN=32: four ports reading distinct and duplicate addresses return correct data.
